// File: rtl/mmio_periph.sv
// mmio_periph: 16-word memory-mapped window with LED outputs, synchronised
// button level/press registers and shadow-buffered servo PWM channels.
// Build macro MMIO_PERIPH_DEBOUNCE_EN adds per-button debounce counters;
// without it the debounced level is the synchroniser output.
module mmio_periph #(
   parameter logic [11:0] BASE_ADDR       = 12'h010,
   parameter int unsigned NUM_LED         = 16,
   parameter int unsigned NUM_BTN         = 4,
   parameter int unsigned NUM_SERVO       = 2,
   parameter int unsigned PERIOD_CYCLES   = 1000000,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [11:0]          addr,
   input  logic                 wr_en,
   input  logic [31:0]          wr_data,
   output logic [31:0]          rd_data,
   output logic                 hit,
   input  logic [NUM_BTN-1:0]   btn_in,
   output logic [NUM_LED-1:0]   led_out,
   output logic [NUM_SERVO-1:0] servo_out
);

   localparam int unsigned WW = 20;
   localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [WW-1:0] WIDTH_RST  = WW'(PERIOD_CYCLES / 20);
   localparam logic [CW-1:0] FRAME_LAST = CW'(PERIOD_CYCLES - 1);

   logic                 in_win_c;
   logic [3:0]           off_c;
   logic                 wr_c;
   logic [NUM_LED-1:0]   led_q;
   logic [NUM_BTN-1:0]   sync1_q;
   logic [NUM_BTN-1:0]   level_q;
   logic [NUM_BTN-1:0]   level_n_c;
   logic [NUM_BTN-1:0]   rise_c;
   logic [NUM_BTN-1:0]   clr_c;
   logic [NUM_BTN-1:0]   press_q;
   logic [31:0]          rd_n_c;
   logic [CW-1:0]        frame_q;
   logic                 frame_zero_c;
   logic [WW-1:0]        width_q  [NUM_SERVO];
   logic [WW-1:0]        shadow_q [NUM_SERVO];
   logic [WW-1:0]        eff_c    [NUM_SERVO];
   logic                 unused_bits;

   // Window decode and write qualification
   assign in_win_c = (addr[11:4] == BASE_ADDR[11:4]);
   assign off_c    = addr[3:0];
   assign wr_c     = wr_en & in_win_c;
   assign unused_bits = ^{wr_data, 32'(DEBOUNCE_CYCLES)};

   // LED register drives the pins directly
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         led_q <= '0;
      end else if (wr_c && off_c == 4'd0) begin
         led_q <= wr_data[NUM_LED-1:0];
      end
   end
   assign led_out = led_q;

`ifdef MMIO_PERIPH_DEBOUNCE_EN
   localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] sync2_q;
   logic [DCW-1:0]     db_cnt_q [NUM_BTN];

   // Level flips on the clock that completes a full run of mismatches
   always_comb begin
      level_n_c = level_q;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         if (sync2_q[i] != level_q[i] && db_cnt_q[i] == DB_LAST) begin
            level_n_c[i] = sync2_q[i];
         end
      end
   end

   // Two-flop synchroniser, debounce counters and debounced level
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         level_q <= level_n_c;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (sync2_q[i] == level_q[i] || db_cnt_q[i] == DB_LAST) begin
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DCW'(1);
            end
         end
      end
   end
`else
   // Second synchroniser stage doubles as the level register
   assign level_n_c = sync1_q;

   // Two-flop synchroniser; level_q is the second stage
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         level_q <= '0;
      end else begin
         sync1_q <= btn_in;
         level_q <= level_n_c;
      end
   end
`endif

   // Press latches: rising debounced edge sets, write-1 clears, set wins
   assign rise_c = level_n_c & ~level_q;
   assign clr_c  = (wr_c && off_c == 4'd2) ? wr_data[NUM_BTN-1:0] : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         press_q <= '0;
      end else begin
         press_q <= (press_q & ~clr_c) | rise_c;
      end
   end

   // Read mux for the addressed register
   always_comb begin
      rd_n_c = '0;
      if (in_win_c) begin
         case (off_c)
            4'd0:    rd_n_c = 32'(led_q);
            4'd1:    rd_n_c = 32'(level_q);
            4'd2:    rd_n_c = 32'(press_q);
            default: begin
               for (int k = 0; k < int'(NUM_SERVO); k++) begin
                  if (off_c == 4'(4 + k)) rd_n_c = 32'(width_q[k]);
               end
            end
         endcase
      end
   end

   // Registered read port
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
         hit     <= 1'b0;
      end else begin
         rd_data <= rd_n_c;
         hit     <= in_win_c;
      end
   end

   // Servo width registers written by the processor
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < int'(NUM_SERVO); k++) width_q[k] <= WIDTH_RST;
      end else begin
         for (int k = 0; k < int'(NUM_SERVO); k++) begin
            if (wr_c && off_c == 4'(4 + k)) width_q[k] <= wr_data[WW-1:0];
         end
      end
   end

   // Shared frame counter
   assign frame_zero_c = (frame_q == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         frame_q <= '0;
      end else if (frame_q == FRAME_LAST) begin
         frame_q <= '0;
      end else begin
         frame_q <= frame_q + CW'(1);
      end
   end

   // At count 0 the fresh width applies immediately, otherwise the shadow
   always_comb begin
      for (int k = 0; k < int'(NUM_SERVO); k++) begin
         eff_c[k] = frame_zero_c ? width_q[k] : shadow_q[k];
      end
   end

   // Shadow load at frame start and registered PWM compare
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         servo_out <= '0;
         for (int k = 0; k < int'(NUM_SERVO); k++) shadow_q[k] <= WIDTH_RST;
      end else begin
         for (int k = 0; k < int'(NUM_SERVO); k++) begin
            if (frame_zero_c) shadow_q[k] <= width_q[k];
            servo_out[k] <= (32'(frame_q) < 32'(eff_c[k]));
         end
      end
   end

endmodule
